// File: rtl/bias_group_sequencer_pkg.sv
// Shared types and constants for the bias group sequencer.
// Lane width, saturation bounds, FSM states and bias bank indexing.
package bias_group_sequencer_pkg;

    localparam int DATA_W = 18;

    localparam logic signed [DATA_W-1:0] SAT_MAX =
        {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN =
        {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // LSB of (group, lane) inside the flattened bias bank bus.
    function automatic int lane_lsb(int grp, int lane, int lanes);
        return DATA_W * (grp * lanes + lane);
    endfunction

endpackage

// File: rtl/bias_group_sequencer_if.sv
// Partial-sum input stream and biased output stream of the sequencer.
// slave is the sequencer side, master the adder tree / downstream side.
interface bias_group_sequencer_if
    import bias_group_sequencer_pkg::*;
#(
    parameter int N_ADDER_TREE = 16,
    parameter int GRP_W        = 6
) ();

    logic                           in_valid;
    logic                           in_ready;
    logic [N_ADDER_TREE*DATA_W-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [N_ADDER_TREE*DATA_W-1:0] out_data;
    logic [GRP_W-1:0]               out_group;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_group
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_group
    );

endinterface

// File: rtl/bias_group_sequencer_sat_add.sv
// Single-lane signed add with clamp to the DATA_W range.
// An overflow is visible as disagreeing top two bits of the wide sum.
module bias_sat_add
    import bias_group_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W:0] sum;

    assign sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};

    always_comb begin
        y = sum[DATA_W-1:0];
        unique case (sum[DATA_W:DATA_W-1])
            2'b01:   y = SAT_MAX;
            2'b10:   y = SAT_MIN;
            default: y = sum[DATA_W-1:0];
        endcase
    end

endmodule

// File: rtl/bias_group_sequencer.sv
// Adds the current group's bias bank to each partial-sum vector of a pass
// and streams the saturated result out with a one-deep output register.
module bias_group_sequencer
    import bias_group_sequencer_pkg::*;
#(
    parameter int N_ADDER_TREE = 16,
    parameter int N_GROUPS     = 32,
    parameter int GRP_W        = 6
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [GRP_W-1:0]                      num_groups,
    input  logic [N_GROUPS*N_ADDER_TREE*DATA_W-1:0] bias_bus,
    bias_group_sequencer_if.slave                 io,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  start_err
);

    localparam int VEC_W = N_ADDER_TREE * DATA_W;
    localparam logic [GRP_W-1:0] GRP_MAX = GRP_W'(N_GROUPS);

    state_t            state_q;
    state_t            state_d;
    logic [GRP_W-1:0]  grp_q;
    logic [GRP_W-1:0]  cnt_q;
    logic [GRP_W-1:0]  out_group_q;
    logic [VEC_W-1:0]  out_data_q;
    logic [VEC_W-1:0]  sum;
    logic              out_valid_q;
    logic              done_q;
    logic              start_err_q;
    logic              in_rdy;
    logic              drain_done;
    logic              in_xfer;
    logic              out_xfer;
    logic              last;

    for (genvar l = 0; l < N_ADDER_TREE; l++) begin : g_lane
        logic [DATA_W-1:0] bias;
        assign bias = bias_bus[lane_lsb(int'(grp_q), l, N_ADDER_TREE) +: DATA_W];
        bias_sat_add u_add (
            .a (io.in_data[DATA_W*l +: DATA_W]),
            .b (bias),
            .y (sum[DATA_W*l +: DATA_W])
        );
    end

    assign out_xfer = out_valid_q && io.out_ready;
    assign in_xfer  = io.in_valid && in_rdy;
    assign last     = (grp_q == cnt_q - GRP_W'(1));

    always_comb begin
        state_d    = state_q;
        in_rdy     = 1'b0;
        drain_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && num_groups != '0) state_d = RUN;
            end
            RUN: begin
                in_rdy = !out_valid_q || io.out_ready;
                if (io.in_valid && in_rdy && last) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_xfer) begin
                    state_d    = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grp_q       <= '0;
            cnt_q       <= '0;
            out_group_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            done_q      <= start && state_q == IDLE && num_groups == '0;
            start_err_q <= start && busy;
            if (start && state_q == IDLE) begin
                cnt_q <= (num_groups > GRP_MAX) ? GRP_MAX : num_groups;
                grp_q <= '0;
            end
            // A same-cycle drain and refill simply reloads the register.
            if (in_xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sum;
                out_group_q <= grp_q;
                if (!last) grp_q <= grp_q + GRP_W'(1);
            end else if (out_xfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign io.in_ready  = in_rdy;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_group = out_group_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q || drain_done;
    assign start_err    = start_err_q;

endmodule
